// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// RegBus/DoubleRegBus are the datapath widths used by EX; DivState and
// DivCnt describe the divider FSM and its iteration counter.
package div_unit_pkg;

  typedef logic [31:0] RegBus;
  typedef logic [63:0] DoubleRegBus;

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_BY_ZERO,
    DIV_ON,
    DIV_END
  } DivState;

  typedef logic [5:0] DivCnt;

  localparam DivCnt DIV_ITERS     = 6'd32;
  localparam RegBus DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // Magnitude as a 32-bit unsigned value; abs(0x80000000) stays 0x80000000.
  function automatic RegBus absVal(input RegBus v, input logic isSigned);
    return (isSigned && v[31]) ? RegBus'(-v) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake bundle.
//   start_i      request (held by EX until result consumed)
//   annul_i      cancel in-flight divide
//   signed_div_i 1 = DIV/REM, 0 = DIVU/REMU
//   opdata1_i    dividend, opdata2_i divisor
//   result_o     {remainder, quotient}, ready_o result valid
interface div_unit_if;
  import div_unit_pkg::*;

  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  RegBus       opdata1_i;
  RegBus       opdata2_i;
  DoubleRegBus result_o;
  logic        ready_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring step (combinational).
//   partIn  {remainder, quotient-in-progress} (65 bits)
//   divisor working (unsigned) divisor
//   partOut value after shift and trial subtract
// partIn[64:31] is the remainder shifted left with the next dividend bit
// appended; the top bit is always 0 because the remainder stays below the
// divisor, so the 34-bit subtract borrow cleanly tells whether it fits.
module div_step
  import div_unit_pkg::*;
(
  input  logic [64:0] partIn,
  input  RegBus       divisor,
  output logic [64:0] partOut
);

  logic [33:0] diff;

  always_comb begin
    diff = partIn[64:31] - {2'b00, divisor};
    if (!diff[33]) begin
      partOut = {diff[32:0], partIn[30:0], 1'b1};
    end else begin
      partOut = {partIn[63:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU.
//   clk    core clock, rising edge
//   rst_n  asynchronous reset, active low
//   bus    div_unit_if.slave: start/annul/signed/operands in,
//          result_o {remainder, quotient} and ready_o out
// Magnitudes are divided unsigned over 32 cycles; signs are restored when
// the result is registered. Divide by zero returns all-ones quotient and
// the original dividend as remainder.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  DivState             state;
  DivCnt               cnt;
  logic [2*DATA_W:0]   work;
  logic [2*DATA_W:0]   workNext;
  logic [DATA_W-1:0]   divisorReg;
  logic [DATA_W-1:0]   dividendRaw;
  logic                negQuot;
  logic                negRem;
  RegBus               quot;
  RegBus               rem;
  logic                unusedTop;

  div_step uStep (
    .partIn  (work),
    .divisor (divisorReg),
    .partOut (workNext)
  );

  assign quot      = work[DATA_W-1:0];
  assign rem       = work[2*DATA_W-1:DATA_W];
  // Remainder guard bit, always 0 once the iterations are done.
  assign unusedTop = work[2*DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= DIV_FREE;
      cnt          <= '0;
      work         <= '0;
      divisorReg   <= '0;
      dividendRaw  <= '0;
      negQuot      <= 1'b0;
      negRem       <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          bus.result_o <= '0;
          bus.ready_o  <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            dividendRaw <= bus.opdata1_i;
            if (bus.opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state      <= DIV_ON;
              cnt        <= '0;
              work       <= {{(DATA_W+1){1'b0}}, absVal(bus.opdata1_i, bus.signed_div_i)};
              divisorReg <= absVal(bus.opdata2_i, bus.signed_div_i);
              negQuot    <= bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
              negRem     <= bus.signed_div_i && bus.opdata1_i[31];
            end
          end
        end

        DIV_BY_ZERO: begin
          if (bus.annul_i) begin
            state <= DIV_FREE;
          end else begin
            state        <= DIV_END;
            bus.result_o <= {dividendRaw, DIV_ZERO_QUOT};
            bus.ready_o  <= 1'b1;
          end
        end

        DIV_ON: begin
          if (bus.annul_i) begin
            state <= DIV_FREE;
            cnt   <= '0;
          end else if (cnt == DIV_ITERS) begin
            state        <= DIV_END;
            bus.result_o <= {negRem  ? RegBus'(-rem)  : rem,
                             negQuot ? RegBus'(-quot) : quot};
            bus.ready_o  <= 1'b1;
          end else begin
            work <= workNext;
            cnt  <= cnt + 1'b1;
          end
        end

        DIV_END: begin
          if (!bus.start_i) begin
            state        <= DIV_FREE;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
          end
        end

        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  div_unit_if bus ();

  div_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one divide, measure the edge index at which ready_o first shows,
  // check result, hold, and release behaviour.
  task automatic runDiv(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int expLat, input logic [63:0] expRes);
    int lat;
    lat = -1;
    @(negedge clk);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 0) begin
        // Operands are captured at E0; later changes must be ignored.
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = 32'h0000_0003;
        bus.signed_div_i = ~s;
      end
      if (bus.ready_o === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != expLat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, expLat);
    end
    checks++;
    if (bus.result_o !== expRes) begin
      failures++;
      $display("FAIL %s result: got %h expected %h", name, bus.result_o, expRes);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== expRes) begin
      failures++;
      $display("FAIL %s hold: ready=%b result=%h expected ready=1 result=%h",
               name, bus.ready_o, bus.result_o, expRes);
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      failures++;
      $display("FAIL %s release: ready=%b result=%h expected ready=0 result=0",
               name, bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      failures++;
      $display("FAIL reset: ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      failures++;
      $display("FAIL idle_after_reset: ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_unsigned();
    runDiv("divu_100_7", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14});
    runDiv("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, {32'd0, 32'hFFFF_FFFF});
  endtask

  task automatic test_signed();
    runDiv("div_m7_2",  32'hFFFF_FFF9, 32'h2, 1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    runDiv("divu_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b0, 33, {32'h0000_0001, 32'h7FFF_FFFC});
    runDiv("div_20_m6", 32'd20, 32'hFFFF_FFFA, 1'b1, 33, {32'd2, 32'hFFFF_FFFD});
  endtask

  task automatic test_div_zero();
    runDiv("div_5_0",  32'd5, 32'd0, 1'b1, 1, {32'd5, 32'hFFFF_FFFF});
    runDiv("divu_5_0", 32'd5, 32'd0, 1'b0, 1, {32'd5, 32'hFFFF_FFFF});
  endtask

  task automatic test_overflow();
    runDiv("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, {32'd0, 32'h8000_0000});
  endtask

  task automatic test_annul();
    logic sawReady;
    logic sawResult;
    sawReady  = 1'b0;
    sawResult = 1'b0;
    @(negedge clk);
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o !== 1'b0) sawReady = 1'b1;
      if (bus.result_o !== 64'd0) sawResult = 1'b1;
    end
    checks++;
    if (sawReady) begin
      failures++;
      $display("FAIL annul_ready: ready rose got 1 expected 0");
    end
    checks++;
    if (sawResult) begin
      failures++;
      $display("FAIL annul_result: result nonzero got %h expected 0", bus.result_o);
    end
    runDiv("divu_9_3", 32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3});
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    for (int n = 0; n <= 20; n++) @(posedge clk);
    #2 rst_n = 1'b0;
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid: ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while a result is being presented must clear it between edges.
    @(negedge clk);
    bus.opdata1_i = 32'd5;
    bus.opdata2_i = 32'd0;
    bus.start_i   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== {32'd5, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL pre_reset_end: ready=%b result=%h expected 1/%h",
               bus.ready_o, bus.result_o, {32'd5, 32'hFFFF_FFFF});
    end
    #2 rst_n = 1'b0;
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      failures++;
      $display("FAIL reset_end: ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    runDiv("divu_after_reset", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, {32'd0, 32'hFFFF_FFFF});
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
